calc_sequencer: RTL and testbench

Input sequencer for the on-screen calculator. It consumes the key code `val` selected by the grid cursor on each one-cycle `sel` pulse and assembles operand A, the operator and operand B from hex digits. It starts the ALU through a start/done handshake, latches the result and drives the value shown on the VGA display. It sits between the grid cursor/button-pulse logic and the ALU, in the VGA clock domain.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/calc_sequencer_if.sv | 26 ++
 rtl/calc_sequencer_operand_reg.sv | 52 +++++
 rtl/calc_sequencer.sv | 140 ++++++++++++++
 tb/tb_calc_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: FSM states, key codes, ALU operator type and key classifiers.
package calc_pkg;

  typedef enum logic [1:0] {
    S_OP1    = 2'd0,
    S_OP2    = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  typedef logic [2:0] alu_op_t;

  localparam logic [4:0] KEY_ADD  = 5'h10;
  localparam logic [4:0] KEY_MUL  = 5'h11;
  localparam logic [4:0] KEY_AND  = 5'h12;
  localparam logic [4:0] KEY_EXE  = 5'h13;
  localparam logic [4:0] KEY_SUB  = 5'h14;
  localparam logic [4:0] KEY_OR   = 5'h15;
  localparam logic [4:0] KEY_CE   = 5'h16;
  localparam logic [4:0] KEY_CLR  = 5'h17;
  localparam logic [4:0] KEY_NONE = 5'h1F;

  function automatic logic is_digit(input logic [4:0] key);
    return ~key[4];
  endfunction

  function automatic logic is_operator(input logic [4:0] key);
    return (key == KEY_ADD) || (key == KEY_MUL) || (key == KEY_AND) ||
           (key == KEY_SUB) || (key == KEY_OR);
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Key-input, ALU handshake and display bus between the cursor/ALU side and the sequencer.
interface calc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             sel;
  logic [4:0]       val;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       alu_op;
  logic             alu_start;
  logic [WIDTH-1:0] disp_val;
  logic             busy;
  logic [1:0]       state_o;

  modport master (
    output sel, val, alu_done, alu_result,
    input  op_a, op_b, alu_op, alu_start, disp_val, busy, state_o
  );

  modport slave (
    input  sel, val, alu_done, alu_result,
    output op_a, op_b, alu_op, alu_start, disp_val, busy, state_o
  );
endinterface

// File: rtl/calc_sequencer_operand_reg.sv
// Hex-digit shift-in operand register with digit counter; clr combined with load_digit
// restarts the operand at that digit. Next-state values are exported for registered display muxing.
module operand_reg #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = WIDTH / 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           load_digit,
  input  logic                           load_value,
  input  logic [3:0]                     digit,
  input  logic [WIDTH-1:0]               value,
  output logic [WIDTH-1:0]               val_o,
  output logic [$clog2(DIGITS+1)-1:0]    cnt_o,
  output logic [WIDTH-1:0]               val_nx_o,
  output logic [$clog2(DIGITS+1)-1:0]    cnt_nx_o
);
  localparam int CW = $clog2(DIGITS + 1);

  logic [WIDTH-1:0] val_q, val_d, base_v;
  logic [CW-1:0]    cnt_q, cnt_d, base_c;

  always_comb begin
    base_v = clr ? '0 : val_q;
    base_c = clr ? '0 : cnt_q;
    val_d  = base_v;
    cnt_d  = base_c;
    if (load_value) begin
      val_d = value;
      cnt_d = CW'(DIGITS);
    end else if (load_digit && (base_c < CW'(DIGITS))) begin
      val_d = {base_v[WIDTH-5:0], digit};
      cnt_d = base_c + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign val_o    = val_q;
  assign cnt_o    = cnt_q;
  assign val_nx_o = val_d;
  assign cnt_nx_o = cnt_d;
endmodule

// File: rtl/calc_sequencer.sv
// Calculator input sequencer: assembles A/op/B from key presses, runs the ALU start/done
// handshake and drives the display value. All outputs registered, one cycle after sel/alu_done.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = WIDTH / 4
) (
  input logic             clk,
  input logic             rst,
  calc_sequencer_if.slave bus
);
  localparam int CW = $clog2(DIGITS + 1);

  state_t           state_q, state_d;
  alu_op_t          alu_op_q, alu_op_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic             a_clr, a_ld, a_lv, b_clr, b_ld;
  logic [WIDTH-1:0] a_q, a_nx, b_q, b_nx;
  logic [CW-1:0]    b_cnt, b_cnt_nx, a_cnt_unused, a_cnt_nx_unused;
  logic             key_digit, key_oper, done_acc;

  operand_reg #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_op_a (
    .clk(clk), .rst(rst), .clr(a_clr), .load_digit(a_ld), .load_value(a_lv),
    .digit(bus.val[3:0]), .value(bus.alu_result),
    .val_o(a_q), .cnt_o(a_cnt_unused), .val_nx_o(a_nx), .cnt_nx_o(a_cnt_nx_unused)
  );

  operand_reg #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_op_b (
    .clk(clk), .rst(rst), .clr(b_clr), .load_digit(b_ld), .load_value(1'b0),
    .digit(bus.val[3:0]), .value('0),
    .val_o(b_q), .cnt_o(b_cnt), .val_nx_o(b_nx), .cnt_nx_o(b_cnt_nx)
  );

  assign key_digit = is_digit(bus.val);
  assign key_oper  = is_operator(bus.val);

  always_comb begin
    state_d  = state_q;
    alu_op_d = alu_op_q;
    start_d  = 1'b0;
    a_clr    = 1'b0;
    a_ld     = 1'b0;
    a_lv     = 1'b0;
    b_clr    = 1'b0;
    b_ld     = 1'b0;
    done_acc = 1'b0;
    case (state_q)
      S_OP1: if (bus.sel) begin
        if (key_digit) a_ld = 1'b1;
        else if (key_oper) begin
          alu_op_d = bus.val[2:0];
          b_clr    = 1'b1;
          state_d  = S_OP2;
        end else if (bus.val == KEY_CE) a_clr = 1'b1;
        else if (bus.val == KEY_CLR) begin
          a_clr    = 1'b1;
          b_clr    = 1'b1;
          alu_op_d = '0;
        end
      end
      S_OP2: if (bus.sel) begin
        if (key_digit) b_ld = 1'b1;
        else if (key_oper) begin
          // Operator can still be changed until the first digit of B arrives.
          if (b_cnt == '0) alu_op_d = bus.val[2:0];
        end else if (bus.val == KEY_CE) b_clr = 1'b1;
        else if (bus.val == KEY_CLR) begin
          a_clr    = 1'b1;
          b_clr    = 1'b1;
          alu_op_d = '0;
          state_d  = S_OP1;
        end else if (bus.val == KEY_EXE) begin
          start_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (bus.alu_done) begin
        a_lv     = 1'b1;
        done_acc = 1'b1;
        state_d  = S_RESULT;
      end
      S_RESULT: if (bus.sel) begin
        if (key_digit) begin
          a_clr   = 1'b1;
          a_ld    = 1'b1;
          state_d = S_OP1;
        end else if (key_oper) begin
          alu_op_d = bus.val[2:0];
          b_clr    = 1'b1;
          state_d  = S_OP2;
        end else if ((bus.val == KEY_CE) || (bus.val == KEY_CLR)) begin
          a_clr    = 1'b1;
          b_clr    = 1'b1;
          alu_op_d = '0;
          state_d  = S_OP1;
        end
      end
      default: state_d = S_OP1;
    endcase
    busy_d = (state_d == S_WAIT);
  end

  // Display follows the next-cycle operands so disp_val lands in the same cycle as op_a/op_b.
  always_comb begin
    disp_d = disp_q;
    case (state_d)
      S_OP1:    disp_d = a_nx;
      S_OP2:    disp_d = (b_cnt_nx == '0) ? a_nx : b_nx;
      S_RESULT: if (done_acc) disp_d = bus.alu_result;
      default:  disp_d = disp_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OP1;
      alu_op_q <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      disp_q   <= disp_d;
    end
  end

  assign bus.op_a      = a_q;
  assign bus.op_b      = b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_start = start_q;
  assign bus.disp_val  = disp_q;
  assign bus.busy      = busy_q;
  assign bus.state_o   = state_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboarded bench for calc_sequencer: directed key sequences then random keys/ALU timing.
module tb_calc_sequencer;
  localparam int W = 16;
  localparam int D = 4;
  localparam int M_OP1 = 0, M_OP2 = 1, M_WAIT = 2, M_RES = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  calc_sequencer_if #(.WIDTH(W)) bus ();
  calc_sequencer #(.WIDTH(W), .DIGITS(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] a, b, disp;
    logic [2:0]  op;
    logic        busy, start;
  } snap_t;
  typedef struct {
    logic [15:0] a, b;
    logic [2:0]  op;
  } start_t;

  snap_t  exp_q[$];
  start_t start_q[$];
  int checks = 0;
  int passes = 0;

  // Behavioural calculator state
  int          m_st, ca, cb;
  logic [15:0] ma, mb, mdisp;
  logic [2:0]  mop;
  logic        mstart;

  function automatic bit is_op(input int k);
    return (k == 'h10) || (k == 'h11) || (k == 'h12) || (k == 'h14) || (k == 'h15);
  endfunction

  function automatic void full_clear();
    ma = 0; mb = 0; ca = 0; cb = 0; mop = 0; m_st = M_OP1;
  endfunction

  function automatic void model_step(input logic s, input logic [4:0] v, input logic d,
                                     input logic [15:0] r);
    int k;
    k = int'(v);
    mstart = 1'b0;
    if (m_st == M_WAIT) begin
      if (d) begin ma = r; mdisp = r; m_st = M_RES; end
    end else if (s) begin
      if (k < 16) begin
        if (m_st == M_RES) begin ma = 16'(k); ca = 1; m_st = M_OP1; end
        else if (m_st == M_OP1) begin
          if (ca < D) begin ma = ma * 16 + 16'(k); ca++; end
        end else if (cb < D) begin mb = mb * 16 + 16'(k); cb++; end
      end else if (is_op(k)) begin
        if (m_st != M_OP2) begin mop = 3'(k % 8); mb = 0; cb = 0; m_st = M_OP2; end
        else if (cb == 0) mop = 3'(k % 8);
      end else if (k == 'h13) begin
        if (m_st == M_OP2) begin mstart = 1'b1; m_st = M_WAIT; end
      end else if (k == 'h16) begin
        if (m_st == M_OP1) begin ma = 0; ca = 0; end
        else if (m_st == M_OP2) begin mb = 0; cb = 0; end
        else full_clear();
      end else if (k == 'h17) full_clear();
    end
    if (m_st == M_OP1) mdisp = ma;
    else if (m_st == M_OP2) mdisp = (cb == 0) ? ma : mb;
  endfunction

  function automatic logic [15:0] ref_alu();
    case (mop)
      3'd0: return ma + mb;
      3'd1: return ma * mb;
      3'd2: return ma & mb;
      3'd4: return ma - mb;
      3'd5: return ma | mb;
      default: return 16'h0;
    endcase
  endfunction

  task automatic drive(input logic s, input logic [4:0] v, input logic d, input logic [15:0] r);
    snap_t  e;
    start_t t;
    @(negedge clk);
    bus.sel = s; bus.val = v; bus.alu_done = d; bus.alu_result = r;
    if (s || d) begin
      model_step(s, v, d, r);
      e.st = 2'(m_st); e.a = ma; e.b = mb; e.disp = mdisp; e.op = mop;
      e.busy = (m_st == M_WAIT); e.start = mstart;
      exp_q.push_back(e);
      if (mstart) begin t.a = ma; t.b = mb; t.op = mop; start_q.push_back(t); end
    end
  endtask

  task automatic press(input logic [4:0] k);
    drive(1'b1, k, 1'b0, 16'h0);
  endtask

  task automatic idle();
    drive(1'b0, 5'h0, 1'b0, 16'h0);
  endtask

  task automatic run_alu(input int dly, input logic with_sel, input logic [4:0] k);
    repeat (dly) idle();
    drive(with_sel, k, 1'b1, ref_alu());
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.sel = 1'b0; bus.alu_done = 1'b0;
    @(negedge clk);
    expect_eq("rst state", 32'(bus.state_o), 0);
    expect_eq("rst op_a/op_b", {bus.op_a, bus.op_b}, 0);
    expect_eq("rst disp", 32'(bus.disp_val), 0);
    expect_eq("rst op/start/busy", {bus.alu_op, bus.alu_start, bus.busy}, 0);
    rst = 1'b0;
    full_clear();
    mdisp = 0; mstart = 1'b0;
  endtask

  // Monitor: one expectation per cycle that carried sel or alu_done.
  logic  ev_q = 1'b0;
  snap_t me;
  start_t ms;
  always @(posedge clk) ev_q <= !rst && (bus.sel || bus.alu_done);

  always @(negedge clk) begin
    if (ev_q) begin
      checks++;
      if (exp_q.size() == 0) $display("FAIL event: no expectation queued");
      else begin
        me = exp_q.pop_front();
        if (bus.state_o === me.st && bus.op_a === me.a && bus.op_b === me.b &&
            bus.disp_val === me.disp && bus.alu_op === me.op && bus.busy === me.busy &&
            bus.alu_start === me.start)
          passes++;
        else
          $display("FAIL step: got st=%0d a=%h b=%h disp=%h op=%0d busy=%b start=%b want st=%0d a=%h b=%h disp=%h op=%0d busy=%b start=%b",
                   bus.state_o, bus.op_a, bus.op_b, bus.disp_val, bus.alu_op, bus.busy, bus.alu_start,
                   me.st, me.a, me.b, me.disp, me.op, me.busy, me.start);
      end
    end
    if (bus.alu_start === 1'b1) begin
      checks++;
      if (start_q.size() == 0) $display("FAIL alu_start: unexpected pulse");
      else begin
        ms = start_q.pop_front();
        if (bus.op_a === ms.a && bus.op_b === ms.b && bus.alu_op === ms.op) passes++;
        else $display("FAIL alu_start ops: got a=%h b=%h op=%0d want a=%h b=%h op=%0d",
                      bus.op_a, bus.op_b, bus.alu_op, ms.a, ms.b, ms.op);
      end
    end
  end

  initial begin
    bus.sel = 1'b0; bus.val = 5'h0; bus.alu_done = 1'b0; bus.alu_result = 16'h0;
    full_clear(); mdisp = 0; mstart = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    for (int k = 1; k <= 5; k++) press(5'(k));
    idle();
    expect_eq("five digits op_a", 32'(bus.op_a), 32'h1234);
    expect_eq("five digits disp", 32'(bus.disp_val), 32'h1234);

    press(5'h17); press(5'h07); press(5'h10); press(5'h05); press(5'h13);
    run_alu(2, 1'b0, 5'h0);
    idle();
    expect_eq("7+5 disp", 32'(bus.disp_val), 32'h000C);
    expect_eq("7+5 busy", 32'(bus.busy), 0);

    press(5'h14); press(5'h02); press(5'h13);
    run_alu(2, 1'b0, 5'h0);
    idle();
    expect_eq("chain C-2 disp", 32'(bus.disp_val), 32'h000A);

    press(5'h09); press(5'h11); press(5'h15);
    idle();
    expect_eq("op replaced", 32'(bus.alu_op), 5);
    press(5'h03); press(5'h12);
    idle();
    expect_eq("op locked", 32'(bus.alu_op), 5);
    press(5'h16);
    idle();
    expect_eq("CE op_b", 32'(bus.op_b), 0);
    expect_eq("CE disp", 32'(bus.disp_val), 32'h0009);

    press(5'h13); press(5'h17); press(5'h06);
    idle();
    expect_eq("wait op_a", 32'(bus.op_a), 32'h0009);
    expect_eq("wait busy", 32'(bus.busy), 1);
    do_reset();
    drive(1'b0, 5'h0, 1'b1, 16'hBEEF);
    idle();
    expect_eq("late done disp", 32'(bus.disp_val), 0);

    press(5'h1F); press(5'h13);
    press(5'h03); press(5'h10); press(5'h04); press(5'h13);
    run_alu(0, 1'b1, 5'h17);
    idle();
    expect_eq("sel+done disp", 32'(bus.disp_val), 32'h0007);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (m_st == M_WAIT) begin
        if (r < 40) run_alu($urandom_range(0, 3), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        else if (r < 60) press(5'($urandom_range(0, 31)));
        else idle();
      end else if (r < 2) do_reset();
      else if (r < 10) idle();
      else if (r < 14) drive(1'b0, 5'h0, 1'b1, 16'($urandom));
      else if (r < 55) press(5'($urandom_range(0, 15)));
      else if (r < 75) begin
        int ops[5] = '{'h10, 'h11, 'h12, 'h14, 'h15};
        press(5'(ops[$urandom_range(0, 4)]));
      end else if (r < 86) press(5'h13);
      else if (r < 91) press(5'h16);
      else if (r < 94) press(5'h17);
      else press(5'($urandom_range(24, 31)));
    end

    if (m_st == M_WAIT) run_alu(1, 1'b0, 5'h0);
    idle(); idle();
    expect_eq("exp queue drained", 32'(exp_q.size()), 0);
    expect_eq("start queue drained", 32'(start_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
